// File: rtl/uart_rx_unit.sv
// ============================================================================
// Module   : uart_rx_unit
// Purpose  : 8N1 UART receiver with oversampled deframer and FWFT byte FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_unit #(
    parameter int CLK_PER_HALF_BIT = 86,
    parameter int FIFO_AW          = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty,
    output logic       frame_err,
    output logic       overrun
);

    localparam int                 c_cw        = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [c_cw-1:0]    c_half_last = c_cw'(CLK_PER_HALF_BIT - 1);
    localparam logic [c_cw-1:0]    c_full_last = c_cw'(2 * CLK_PER_HALF_BIT - 1);
    localparam int                 c_depth_i   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   c_depth     = (FIFO_AW + 1)'(c_depth_i);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic              r_sync1;
    logic              r_sync2;
    logic              w_rxs;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nx;
    logic [c_cw-1:0]   r_cnt;
    logic [2:0]        r_bitn;
    logic [7:0]        r_shreg;
    logic              r_armed;

    logic              w_cnt_clr;
    logic              w_data_smp;
    logic              w_push;
    logic              w_ferr;

    logic [7:0]        r_mem [c_depth_i];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]  r_count;
    logic              w_pop;
    logic              w_push_ok;

    assign w_rxs = r_sync2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_st_idle: begin
                if (!w_rxs && r_armed) w_state_nx = c_st_start;
            end
            c_st_start: begin
                if (r_cnt == c_half_last) w_state_nx = w_rxs ? c_st_idle : c_st_data;
            end
            c_st_data: begin
                if (r_cnt == c_full_last && r_bitn == 3'd7) w_state_nx = c_st_stop;
            end
            c_st_stop: begin
                if (r_cnt == c_full_last) w_state_nx = c_st_idle;
            end
            default: w_state_nx = c_st_idle;
        endcase
    end

    always_comb begin
        w_cnt_clr  = 1'b0;
        w_data_smp = 1'b0;
        w_push     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            c_st_idle:  w_cnt_clr = 1'b1;
            c_st_start: w_cnt_clr = (r_cnt == c_half_last);
            c_st_data: begin
                w_cnt_clr  = (r_cnt == c_full_last);
                w_data_smp = (r_cnt == c_full_last);
            end
            c_st_stop: begin
                w_cnt_clr = (r_cnt == c_full_last);
                w_push    = (r_cnt == c_full_last) && w_rxs;
                w_ferr    = (r_cnt == c_full_last) && !w_rxs;
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    // A break leaves the line low after the stop sample; hold off new starts
    // until the line has been seen high again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_shreg <= '0;
            r_armed <= 1'b1;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_state != c_st_data) begin
                r_bitn <= '0;
            end else if (w_data_smp) begin
                r_bitn <= r_bitn + 1'b1;
            end
            if (w_data_smp) r_shreg[r_bitn] <= w_rxs;
            if (w_ferr) begin
                r_armed <= 1'b0;
            end else if (w_rxs) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign empty     = (r_count == '0);
    assign w_pop     = rd_en && !empty;
    assign w_push_ok = w_push && ((r_count < c_depth) || w_pop);
    assign dout      = empty ? 8'h00 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= r_shreg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            frame_err <= w_ferr;
            overrun   <= w_push && !w_push_ok;
        end
    end

endmodule

`default_nettype wire
